pwm_gen_multi: RTL and testbench

Parametrised N-channel PWM generator with complementary outputs, programmable dead time, edge- or center-aligned counting and double-buffered duty updates. It replaces the fixed three-phase PWM stage at the back of the FOC datapath. It takes per-channel duty words from the SVM/inverse-Park stage over a valid/ready handshake and drives high-side and low-side gate signals. Duty, period and dead time change only at a period boundary, so a mid-period write never produces a glitch.

---
 rtl/pwm_gen_multi.sv | 180 ++++++++++++++++++
 tb/tb_pwm_gen_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: N-channel complementary PWM with dead time, edge/center
// aligned counting and a double-buffered duty update path.

// Per-channel dead-time inserter: both gates drop on a raw edge, the new
// side asserts once raw has stayed put for the loaded dead time.
module pwm_gen_multi_dt #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] dt,
    output logic                hi,
    output logic                lo
);
    logic                r_raw_q;
    logic [DT_WIDTH-1:0] r_dcnt;
    logic                r_hi;
    logic                r_lo;

    // raw edge tracking, dead-time countdown and gate registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw_q <= 1'b0;
            r_dcnt  <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
        end else if (!enable) begin
            // track raw silently so re-enable does not look like an edge
            r_raw_q <= raw;
            r_dcnt  <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
        end else if (raw != r_raw_q) begin
            r_raw_q <= raw;
            if (dt == '0) begin
                r_dcnt <= '0;
                r_hi   <= raw;
                r_lo   <= !raw;
            end else begin
                r_dcnt <= dt;
                r_hi   <= 1'b0;
                r_lo   <= 1'b0;
            end
        end else if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 1'b1;
            if (r_dcnt == DT_WIDTH'(1)) begin
                r_hi <= r_raw_q;
                r_lo <= !r_raw_q;
            end
        end else begin
            r_hi <= r_raw_q;
            r_lo <= !r_raw_q;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;
endmodule

module pwm_gen_multi #(
    parameter int N_CH      = 3,
    parameter int CNT_WIDTH = 19,
    parameter int DT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [CNT_WIDTH-1:0]      period_top,
    input  logic [DT_WIDTH-1:0]       deadtime,
    input  logic [N_CH*CNT_WIDTH-1:0] duty_in,
    input  logic                      valid,
    output logic                      ready,
    output logic [N_CH-1:0]           pwm_hi,
    output logic [N_CH-1:0]           pwm_lo,
    output logic                      period_start
);
    logic [CNT_WIDTH-1:0]            r_cnt;
    logic                            r_dir_dn;
    logic                            r_run;
    logic [CNT_WIDTH-1:0]            r_top;
    logic                            r_mode;
    logic [DT_WIDTH-1:0]             r_dt;
    logic [N_CH-1:0][CNT_WIDTH-1:0]  r_duty;
    logic [N_CH-1:0][CNT_WIDTH-1:0]  r_shadow;
    logic                            r_pending;
    logic                            r_pstart;

    logic [CNT_WIDTH-1:0]            w_cnt_nxt;
    logic                            w_dir_dn_nxt;
    logic                            w_wrap;
    logic [N_CH-1:0]                 w_raw;

    // counter next state; r_run delays the first count after enable so the
    // opening cnt==0 cycle is a full period-start cycle
    always_comb begin
        w_cnt_nxt    = '0;
        w_dir_dn_nxt = 1'b0;
        if (enable && r_run && r_top != '0) begin
            if (!r_mode) begin
                w_cnt_nxt = (r_cnt >= r_top) ? '0 : r_cnt + 1'b1;
            end else if (!r_dir_dn) begin
                if (r_cnt >= r_top) begin
                    w_cnt_nxt    = r_top - 1'b1;
                    w_dir_dn_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else if (r_cnt > CNT_WIDTH'(1)) begin
                w_cnt_nxt    = r_cnt - 1'b1;
                w_dir_dn_nxt = 1'b1;
            end
        end
        // every period starts counting up
        if (w_cnt_nxt == '0) w_dir_dn_nxt = 1'b0;
        w_wrap = (w_cnt_nxt == '0);
    end

    // counter, active period config and period_start flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dir_dn <= 1'b0;
            r_run    <= 1'b0;
            r_top    <= '0;
            r_mode   <= 1'b0;
            r_dt     <= '0;
            r_pstart <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_dir_dn <= w_dir_dn_nxt;
            r_run    <= enable;
            r_pstart <= enable && w_wrap;
            if (w_wrap) begin
                r_top  <= period_top;
                r_mode <= mode;
                r_dt   <= deadtime;
            end
        end
    end

    // shadow buffer: capture when empty, promote to active at a wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_duty    <= r_shadow;
                r_pending <= 1'b0;
            end
            if (valid && !r_pending) begin
                r_shadow  <= duty_in;
                r_pending <= 1'b1;
            end
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < N_CH; ch++) begin : g_ch
            assign w_raw[ch] = (r_cnt < r_duty[ch]);
            pwm_gen_multi_dt #(.DT_WIDTH(DT_WIDTH)) u_dt (
                .clk    (clk),
                .rst    (rst),
                .enable (enable),
                .raw    (w_raw[ch]),
                .dt     (r_dt),
                .hi     (pwm_hi[ch]),
                .lo     (pwm_lo[ch])
            );
        end
    endgenerate

    assign ready        = !r_pending;
    assign period_start = r_pstart;
endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: cycle reference model built from period
// position arithmetic and raw run-lengths, directed steps then random.
module tb_pwm_gen_multi;
    localparam int N   = 3;
    localparam int CW  = 19;
    localparam int DW  = 8;
    localparam int BIG = 1 << 30;

    logic            clk = 1'b0;
    logic            rst, enable, mode, valid;
    logic [CW-1:0]   period_top;
    logic [DW-1:0]   deadtime;
    logic [N*CW-1:0] duty_in;
    logic            ready, period_start;
    logic [N-1:0]    pwm_hi, pwm_lo;

    pwm_gen_multi #(.N_CH(N), .CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .period_top(period_top), .deadtime(deadtime), .duty_in(duty_in),
        .valid(valid), .ready(ready), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // reference model state
    int m_run, m_p, m_top, m_mode, m_dt, m_pend;
    int m_duty[N], m_sh[N], m_val[N], m_len[N], m_dl[N];
    logic [N-1:0] e_hi, e_lo;
    logic e_ps;
    int c_hi[N], c_lo[N], c_both[N], c_ps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_p = 0; m_top = 0; m_mode = 0; m_dt = 0; m_pend = 0;
        for (int c = 0; c < N; c++) begin
            m_duty[c] = 0; m_sh[c] = 0; m_val[c] = 0; m_len[c] = BIG; m_dl[c] = 0;
        end
        e_hi = '0; e_lo = '0; e_ps = 1'b0;
    endtask

    // one clock edge of the reference model, using inputs as sampled
    task automatic model_edge();
        int cnt, per, pn, raw;
        if (rst) begin
            model_reset();
        end else begin
            cnt = (m_mode != 0 && m_p > m_top) ? 2 * m_top - m_p : m_p;
            for (int c = 0; c < N; c++) begin
                raw = (cnt < m_duty[c]) ? 1 : 0;
                if (!enable) begin
                    m_val[c] = raw; m_len[c] = BIG;
                    e_hi[c] = 1'b0; e_lo[c] = 1'b0;
                end else begin
                    if (raw != m_val[c]) begin
                        m_val[c] = raw; m_len[c] = 1; m_dl[c] = m_dt;
                    end else if (m_len[c] < BIG) begin
                        m_len[c]++;
                    end
                    e_hi[c] = (m_val[c] == 1) && (m_len[c] >= m_dl[c] + 1);
                    e_lo[c] = (m_val[c] == 0) && (m_len[c] >= m_dl[c] + 1);
                end
            end
            if (m_top == 0)       per = 1;
            else if (m_mode != 0) per = 2 * m_top;
            else                  per = m_top + 1;
            pn = (enable && m_run != 0) ? (m_p + 1) % per : 0;
            e_ps = enable && (pn == 0);
            if (pn == 0 && m_pend != 0) begin
                for (int c = 0; c < N; c++) m_duty[c] = m_sh[c];
                m_pend = 0;
            end else if (valid && m_pend == 0) begin
                for (int c = 0; c < N; c++) m_sh[c] = int'(duty_in[c*CW +: CW]);
                m_pend = 1;
            end
            if (pn == 0) begin
                m_top = int'(period_top); m_mode = int'(mode); m_dt = int'(deadtime);
            end
            m_p = pn;
            m_run = enable ? 1 : 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pwm_hi", 32'(pwm_hi), 32'(e_hi));
        chk("pwm_lo", 32'(pwm_lo), 32'(e_lo));
        chk("period_start", 32'(period_start), 32'(e_ps));
        chk("ready", 32'(ready), (m_pend == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic write_duty(input int d0, input int d1, input int d2);
        duty_in = {CW'(d2), CW'(d1), CW'(d0)};
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic measure(input int n);
        c_ps = 0;
        for (int c = 0; c < N; c++) begin c_hi[c] = 0; c_lo[c] = 0; c_both[c] = 0; end
        for (int i = 0; i < n; i++) begin
            step();
            c_ps += int'(period_start);
            for (int c = 0; c < N; c++) begin
                c_hi[c] += int'(pwm_hi[c]);
                c_lo[c] += int'(pwm_lo[c]);
                c_both[c] += int'(!pwm_hi[c] && !pwm_lo[c]);
            end
        end
    endtask

    task automatic wait_ps();
        int k = 0;
        while (period_start !== 1'b1 && k < 100) begin step(); k++; end
        chk("wait_period_start", 32'(period_start), 32'd1);
    endtask

    initial begin
        int r, t;
        rst = 1'b1; enable = 1'b0; mode = 1'b0; valid = 1'b0;
        period_top = '0; deadtime = '0; duty_in = '0;
        model_reset();

        // reset
        step(); step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_hi", 32'(pwm_hi), 32'd0);
        chk("rst_lo", 32'(pwm_lo), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);

        // edge mode, top 9, duties 3 / 0 / 12
        rst = 1'b0; enable = 1'b1; period_top = 9;
        write_duty(3, 0, 12);
        repeat (25) step();
        measure(10);
        chk("edge_hi0", c_hi[0], 3);
        chk("edge_lo0", c_lo[0], 7);
        chk("edge_ps", c_ps, 1);
        chk("duty0_hi", c_hi[1], 0);
        chk("duty0_lo", c_lo[1], 10);
        chk("clamp_hi", c_hi[2], 10);

        // center mode, top 8, dead time 2, duty 4
        mode = 1'b1; period_top = 8; deadtime = 2;
        write_duty(4, 4, 4);
        repeat (40) step();
        measure(16);
        chk("ctr_hi", c_hi[0], 5);
        chk("ctr_lo", c_lo[0], 7);
        chk("ctr_gap", c_both[0], 4);
        chk("ctr_ps", c_ps, 1);

        // shadow update mid-period, second write ignored
        mode = 1'b0; period_top = 9; deadtime = 0;
        write_duty(3, 3, 3);
        repeat (30) step();
        wait_ps();
        repeat (4) step();
        write_duty(6, 6, 6);
        chk("shd_busy", 32'(ready), 32'd0);
        write_duty(1, 1, 1);
        wait_ps();
        chk("shd_ready", 32'(ready), 32'd1);
        repeat (10) step();
        measure(10);
        chk("shd_new", c_hi[0], 6);
        measure(10);
        chk("shd_ignored", c_hi[0], 6);

        // dead time longer than the raw pulse
        deadtime = 5;
        write_duty(3, 3, 3);
        repeat (30) step();
        measure(10);
        chk("swallow_hi", c_hi[0], 0);
        chk("swallow_lo", c_lo[0], 2);

        // enable drop with an update pending
        deadtime = 0;
        write_duty(5, 5, 5);
        enable = 1'b0;
        step();
        chk("dis_ready", 32'(ready), 32'd1);
        chk("dis_hi", 32'(pwm_hi), 32'd0);
        repeat (3) step();
        enable = 1'b1;
        step();
        chk("en_ps", 32'(period_start), 32'd1);
        repeat (20) step();
        measure(10);
        chk("en_duty", c_hi[0], 5);

        // reset with an update pending
        write_duty(8, 8, 8);
        rst = 1'b1;
        step();
        chk("rstp_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        repeat (20) step();
        measure(10);
        chk("rstp_hi", c_hi[0], 0);
        chk("rstp_lo", c_lo[0], 10);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 10) begin
                mode = 1'($urandom_range(0, 1));
                period_top = CW'($urandom_range(1, 12));
                deadtime = DW'($urandom_range(0, 4));
            end else if (r < 15) begin
                enable = !enable;
            end else if (r < 17) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            if (r >= 900) begin
                t = int'(period_top) + 3;
                duty_in = {CW'($urandom_range(0, t)), CW'($urandom_range(0, t)),
                           CW'($urandom_range(0, t))};
                valid = 1'b1;
            end
            step();
            valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
